// File: rtl/mc_ctrl.sv
// Multi-cycle instruction controller: sequences fetch/decode/exec/mem/wb.
// Latency: j/jal/jr 2, branch 3, R/imm 4, sw 4, lw 5 cycles plus memory waits.
// Backpressure: waits in FETCH/MEM for mem_ready; TIMEOUT idle cycles -> HALT.
//
// Ports:
//   clk, rst_n          clock, async active-low reset
//   op_in, func_in      instruction fields from memory read data (latched on ir_we)
//   alu_zero            ALU zero flag, used by beq/bne in EXEC
//   mem_ready           memory completes the request (FETCH/MEM only)
//   mem_req/sel/we      memory request, 0 instr / 1 data, write enable
//   ir_we, pc_we,pc_src instruction register / PC write controls
//   reg_we, reg_dst,
//   mem_to_reg          register file write controls
//   alu_src, ext_mode,
//   alu_op              ALU operand/operation select
//   state, retire,
//   halted, fault       status
module mc_ctrl #(
   parameter int TIMEOUT = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [5:0] op_in,
   input  logic [5:0] func_in,
   input  logic       alu_zero,
   input  logic       mem_ready,
   output logic       mem_req,
   output logic       mem_sel,
   output logic       mem_we,
   output logic       ir_we,
   output logic       pc_we,
   output logic [1:0] pc_src,
   output logic       reg_we,
   output logic [1:0] reg_dst,
   output logic [1:0] mem_to_reg,
   output logic       alu_src,
   output logic       ext_mode,
   output logic [2:0] alu_op,
   output logic [2:0] state,
   output logic       retire,
   output logic       halted,
   output logic [1:0] fault
);

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_HALT   = 3'd7
   } st_t;

   localparam logic [1:0] FLT_NONE    = 2'd0;
   localparam logic [1:0] FLT_ILLEGAL = 2'd1;
   localparam logic [1:0] FLT_TIMEOUT = 2'd2;

   localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT - 1);

   st_t           cur;
   logic [5:0]    op_r;
   logic [5:0]    func_r;
   logic [CW-1:0] wait_cnt;
   logic [1:0]    fault_r;

   // Decode of the latched instruction only; op_in/func_in are never looked at
   // after the fetch cycle.
   logic is_r, is_j, is_jal, is_jr, is_sys, is_beq, is_bne, is_br;
   logic is_lw, is_sw, supported;

   always_comb begin
      is_r    = (op_r == 6'h00);
      is_j    = (op_r == 6'h02);
      is_jal  = (op_r == 6'h03);
      is_jr   = is_r && (func_r == 6'h08);
      is_sys  = is_r && (func_r == 6'h0C);
      is_beq  = (op_r == 6'h04);
      is_bne  = (op_r == 6'h05);
      is_br   = is_beq || is_bne;
      is_lw   = (op_r == 6'h23);
      is_sw   = (op_r == 6'h2B);
      supported = 1'b0;
      case (op_r)
         6'h00, 6'h04, 6'h05, 6'h08, 6'h0A,
         6'h0C, 6'h0D, 6'h0F, 6'h23, 6'h2B: supported = 1'b1;
         default:                            supported = 1'b0;
      endcase
   end

   // ALU controls implied by the latched opcode.
   logic [2:0] dec_alu_op;
   logic       dec_alu_src;
   logic       dec_ext;

   always_comb begin
      dec_alu_op  = 3'd0;
      dec_alu_src = 1'b0;
      dec_ext     = 1'b0;
      case (op_r)
         6'h00:        begin dec_alu_op = 3'd2; dec_alu_src = 1'b0; dec_ext = 1'b0; end
         6'h04, 6'h05: begin dec_alu_op = 3'd1; dec_alu_src = 1'b0; dec_ext = 1'b0; end
         6'h23, 6'h2B: begin dec_alu_op = 3'd0; dec_alu_src = 1'b1; dec_ext = 1'b1; end
         6'h08:        begin dec_alu_op = 3'd0; dec_alu_src = 1'b1; dec_ext = 1'b1; end
         6'h0A:        begin dec_alu_op = 3'd5; dec_alu_src = 1'b1; dec_ext = 1'b1; end
         6'h0C:        begin dec_alu_op = 3'd3; dec_alu_src = 1'b1; dec_ext = 1'b0; end
         6'h0D:        begin dec_alu_op = 3'd4; dec_alu_src = 1'b1; dec_ext = 1'b0; end
         6'h0F:        begin dec_alu_op = 3'd6; dec_alu_src = 1'b1; dec_ext = 1'b0; end
         default:      begin dec_alu_op = 3'd0; dec_alu_src = 1'b0; dec_ext = 1'b0; end
      endcase
   end

   // State, latched instruction, wait counter and fault code.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cur      <= S_FETCH;
         op_r     <= 6'd0;
         func_r   <= 6'd0;
         wait_cnt <= '0;
         fault_r  <= FLT_NONE;
      end else begin
         // Counter only survives across consecutive waiting cycles, so it is
         // zero on every entry to FETCH or MEM.
         wait_cnt <= '0;
         case (cur)
            S_FETCH: begin
               if (mem_ready) begin
                  op_r   <= op_in;
                  func_r <= func_in;
                  cur    <= S_DECODE;
               end else if (wait_cnt == WAIT_LAST) begin
                  cur     <= S_HALT;
                  fault_r <= FLT_TIMEOUT;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end
            S_DECODE: begin
               if (is_j || is_jal || is_jr) begin
                  cur <= S_FETCH;
               end else if (is_sys) begin
                  cur <= S_HALT;
               end else if (supported) begin
                  cur <= S_EXEC;
               end else begin
                  cur     <= S_HALT;
                  fault_r <= FLT_ILLEGAL;
               end
            end
            S_EXEC: begin
               if (is_br)               cur <= S_FETCH;
               else if (is_lw || is_sw) cur <= S_MEM;
               else                     cur <= S_WB;
            end
            S_MEM: begin
               if (mem_ready) begin
                  cur <= is_sw ? S_FETCH : S_WB;
               end else if (wait_cnt == WAIT_LAST) begin
                  cur     <= S_HALT;
                  fault_r <= FLT_TIMEOUT;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end
            S_WB:    cur <= S_FETCH;
            S_HALT:  cur <= S_HALT;
            default: cur <= S_FETCH;
         endcase
      end
   end

   // Strobes and controls are decoded from the current state so they can act
   // on mem_ready/alu_zero in the same cycle; all of them are forced low while
   // reset is asserted.
   always_comb begin
      mem_req    = 1'b0;
      mem_sel    = 1'b0;
      mem_we     = 1'b0;
      ir_we      = 1'b0;
      pc_we      = 1'b0;
      pc_src     = 2'd0;
      reg_we     = 1'b0;
      reg_dst    = 2'd0;
      mem_to_reg = 2'd0;
      alu_src    = 1'b0;
      ext_mode   = 1'b0;
      alu_op     = 3'd0;
      retire     = 1'b0;
      if (rst_n) begin
         case (cur)
            S_FETCH: begin
               mem_req = 1'b1;
               if (mem_ready) begin
                  ir_we = 1'b1;
                  pc_we = 1'b1;
               end
            end
            S_DECODE: begin
               if (is_j || is_jal) begin
                  pc_we  = 1'b1;
                  pc_src = 2'd2;
                  retire = 1'b1;
                  if (is_jal) begin
                     reg_we     = 1'b1;
                     reg_dst    = 2'd2;
                     mem_to_reg = 2'd2;
                  end
               end else if (is_jr) begin
                  pc_we  = 1'b1;
                  pc_src = 2'd3;
                  retire = 1'b1;
               end else if (is_sys) begin
                  retire = 1'b1;
               end
            end
            S_EXEC: begin
               alu_op   = dec_alu_op;
               alu_src  = dec_alu_src;
               ext_mode = dec_ext;
               if (is_br) begin
                  pc_src = 2'd1;
                  pc_we  = is_beq ? alu_zero : ~alu_zero;
                  retire = 1'b1;
               end
            end
            S_MEM: begin
               alu_op   = dec_alu_op;
               alu_src  = dec_alu_src;
               ext_mode = dec_ext;
               mem_req  = 1'b1;
               mem_sel  = 1'b1;
               mem_we   = is_sw;
               retire   = mem_ready && is_sw;
            end
            S_WB: begin
               alu_op     = dec_alu_op;
               alu_src    = dec_alu_src;
               ext_mode   = dec_ext;
               reg_we     = 1'b1;
               reg_dst    = {1'b0, is_r};
               mem_to_reg = {1'b0, is_lw};
               retire     = 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign state  = cur;
   assign halted = (cur == S_HALT);
   assign fault  = fault_r;

endmodule

// File: tb/tb_mc_ctrl.sv
// Bench for mc_ctrl: per-instruction expected cycle traces built from the
// instruction class and memory wait counts, played into the DUT and compared
// every cycle; random instruction mix, waits, timeouts and mid-flight resets.
module tb_mc_ctrl;

   localparam int TO = 16;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [5:0] op_in = '0;
   logic [5:0] func_in = '0;
   logic       alu_zero = 1'b0;
   logic       mem_ready = 1'b0;
   logic       mem_req, mem_sel, mem_we, ir_we, pc_we, reg_we;
   logic [1:0] pc_src, reg_dst, mem_to_reg, fault;
   logic       alu_src, ext_mode, retire, halted;
   logic [2:0] alu_op, state;

   mc_ctrl #(.TIMEOUT(TO)) dut (
      .clk(clk), .rst_n(rst_n), .op_in(op_in), .func_in(func_in),
      .alu_zero(alu_zero), .mem_ready(mem_ready),
      .mem_req(mem_req), .mem_sel(mem_sel), .mem_we(mem_we),
      .ir_we(ir_we), .pc_we(pc_we), .pc_src(pc_src),
      .reg_we(reg_we), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
      .alu_src(alu_src), .ext_mode(ext_mode), .alu_op(alu_op),
      .state(state), .retire(retire), .halted(halted), .fault(fault)
   );

   always #5 clk = ~clk;

   // One cycle: stimulus to drive plus outputs that must be seen.
   typedef struct packed {
      logic       rst;
      logic [5:0] op;
      logic [5:0] func;
      logic       zero;
      logic       rdy;
      logic [2:0] st;
      logic       req, sel, we, ir, pcw;
      logic [1:0] pcs;
      logic       rw;
      logic [1:0] rd, m2r;
      logic       asrc, ext;
      logic [2:0] aop;
      logic       ret, hlt;
      logic [1:0] flt;
      logic       chk_alu, chk_ext;
   } cyc_t;

   cyc_t tr[$];   // trace of the instruction being built
   cyc_t q[$];    // cycles awaiting comparison
   cyc_t ce;
   int   checks = 0;
   int   errors = 0;

   task automatic chk(input string n, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0d expected %0d", n, $time, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (q.size() > 0) begin
         ce = q.pop_front();
         chk("state", 8'(state), 8'(ce.st));
         chk("mem_req", 8'(mem_req), 8'(ce.req));
         chk("mem_sel", 8'(mem_sel), 8'(ce.sel));
         chk("mem_we", 8'(mem_we), 8'(ce.we));
         chk("ir_we", 8'(ir_we), 8'(ce.ir));
         chk("pc_we", 8'(pc_we), 8'(ce.pcw));
         chk("pc_src", 8'(pc_src), 8'(ce.pcs));
         chk("reg_we", 8'(reg_we), 8'(ce.rw));
         chk("reg_dst", 8'(reg_dst), 8'(ce.rd));
         chk("mem_to_reg", 8'(mem_to_reg), 8'(ce.m2r));
         chk("retire", 8'(retire), 8'(ce.ret));
         chk("halted", 8'(halted), 8'(ce.hlt));
         chk("fault", 8'(fault), 8'(ce.flt));
         if (ce.chk_alu) begin
            chk("alu_op", 8'(alu_op), 8'(ce.aop));
            chk("alu_src", 8'(alu_src), 8'(ce.asrc));
         end
         if (ce.chk_ext) chk("ext_mode", 8'(ext_mode), 8'(ce.ext));
      end
   end

   // Cycle with no strobes; unconstrained stimulus is randomized so that
   // stray op_in/mem_ready/alu_zero values must be ignored by the DUT.
   function automatic cyc_t quiet(input logic [2:0] st, input logic [1:0] flt);
      cyc_t c;
      c      = '0;
      c.rst  = 1'b1;
      c.op   = 6'($urandom);
      c.func = 6'($urandom);
      c.zero = 1'($urandom);
      c.rdy  = 1'($urandom);
      c.st   = st;
      c.hlt  = (st == 3'd7);
      c.flt  = flt;
      return c;
   endfunction

   function automatic bit legal(input logic [5:0] op);
      return op inside {6'h00, 6'h04, 6'h05, 6'h08, 6'h0A, 6'h0C, 6'h0D, 6'h0F, 6'h23, 6'h2B};
   endfunction

   // ALU settings from the opcode table; ext is only defined for immediates
   // and memory ops.
   function automatic cyc_t with_alu(input cyc_t c0, input logic [5:0] op);
      cyc_t c;
      c = c0;
      c.chk_alu = 1'b1;
      c.chk_ext = 1'b1;
      case (op)
         6'h00:        begin c.aop = 3'd2; c.asrc = 1'b0; c.chk_ext = 1'b0; end
         6'h04, 6'h05: begin c.aop = 3'd1; c.asrc = 1'b0; c.chk_ext = 1'b0; end
         6'h23, 6'h2B: begin c.aop = 3'd0; c.asrc = 1'b1; c.ext = 1'b1; end
         6'h08:        begin c.aop = 3'd0; c.asrc = 1'b1; c.ext = 1'b1; end
         6'h0A:        begin c.aop = 3'd5; c.asrc = 1'b1; c.ext = 1'b1; end
         6'h0C:        begin c.aop = 3'd3; c.asrc = 1'b1; c.ext = 1'b0; end
         6'h0D:        begin c.aop = 3'd4; c.asrc = 1'b1; c.ext = 1'b0; end
         default:      begin c.aop = 3'd6; c.asrc = 1'b1; c.ext = 1'b0; end
      endcase
      return c;
   endfunction

   task automatic add_halt(input logic [1:0] flt, input int n);
      for (int i = 0; i < n; i++) tr.push_back(quiet(3'd7, flt));
   endtask

   // Expected trace of one instruction. fw/mw are memory wait cycles in
   // FETCH/MEM (>= TO means timeout); hl is how many HALT cycles to watch.
   task automatic build(input logic [5:0] op, input logic [5:0] func, input logic zero,
                        input int fw, input int mw, input int hl);
      cyc_t c;
      tr.delete();
      for (int i = 0; i < fw && i < TO; i++) begin
         c = quiet(3'd0, 2'd0); c.rdy = 1'b0; c.req = 1'b1; tr.push_back(c);
      end
      if (fw >= TO) begin add_halt(2'd2, hl); return; end
      c = quiet(3'd0, 2'd0);
      c.rdy = 1'b1; c.op = op; c.func = func; c.req = 1'b1; c.ir = 1'b1; c.pcw = 1'b1;
      tr.push_back(c);
      c = quiet(3'd1, 2'd0);
      if (op == 6'h02 || op == 6'h03 || (op == 6'h00 && func == 6'h08)) begin
         c.pcw = 1'b1; c.ret = 1'b1;
         c.pcs = (op == 6'h00) ? 2'd3 : 2'd2;
         if (op == 6'h03) begin c.rw = 1'b1; c.rd = 2'd2; c.m2r = 2'd2; end
         tr.push_back(c);
         return;
      end
      if (op == 6'h00 && func == 6'h0C) begin
         c.ret = 1'b1; tr.push_back(c); add_halt(2'd0, hl); return;
      end
      tr.push_back(c);
      if (!legal(op)) begin add_halt(2'd1, hl); return; end
      c = with_alu(quiet(3'd2, 2'd0), op);
      if (op == 6'h04 || op == 6'h05) begin
         c.zero = zero; c.pcs = 2'd1; c.ret = 1'b1;
         c.pcw = (op == 6'h04) ? zero : ~zero;
         tr.push_back(c);
         return;
      end
      tr.push_back(c);
      if (op == 6'h23 || op == 6'h2B) begin
         for (int i = 0; i < mw && i < TO; i++) begin
            c = quiet(3'd3, 2'd0);
            c.rdy = 1'b0; c.req = 1'b1; c.sel = 1'b1; c.we = (op == 6'h2B);
            tr.push_back(c);
         end
         if (mw >= TO) begin add_halt(2'd2, hl); return; end
         c = quiet(3'd3, 2'd0);
         c.rdy = 1'b1; c.req = 1'b1; c.sel = 1'b1; c.we = (op == 6'h2B);
         c.ret = (op == 6'h2B);
         tr.push_back(c);
         if (op == 6'h2B) return;
      end
      c = quiet(3'd4, 2'd0);
      if (op != 6'h23) c = with_alu(c, op);
      c.rw = 1'b1; c.rd = (op == 6'h00) ? 2'd1 : 2'd0;
      c.m2r = (op == 6'h23) ? 2'd1 : 2'd0; c.ret = 1'b1;
      tr.push_back(c);
   endtask

   task automatic play(input int cut);
      for (int i = 0; i < tr.size() && i < cut; i++) begin
         @(posedge clk); #1;
         rst_n = tr[i].rst; op_in = tr[i].op; func_in = tr[i].func;
         alu_zero = tr[i].zero; mem_ready = tr[i].rdy;
         q.push_back(tr[i]);
      end
   endtask

   task automatic do_reset(input int n);
      cyc_t c;
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
         c = quiet(3'd0, 2'd0); c.rst = 1'b0; c.rdy = 1'b1;
         rst_n = 1'b0; op_in = c.op; func_in = c.func;
         alu_zero = c.zero; mem_ready = c.rdy;
         q.push_back(c);
      end
   endtask

   task automatic pin(input string n, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: model gives %0d expected %0d", n, act, exp);
      end
   endtask

   function automatic int retires();
      int n = 0;
      foreach (tr[i]) n += int'(tr[i].ret);
      return n;
   endfunction

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [5:0] op, func;
      int fw, mw, cut;
      logic [5:0] pool [12];
      pool = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h0A, 6'h0C,
               6'h0D, 6'h0F, 6'h23, 6'h2B};

      do_reset(3);

      // add: FETCH, DECODE, EXEC, WB with one retire, rd select only in WB.
      build(6'h00, 6'h20, 1'b0, 0, 0, 0);
      pin("add_len", tr.size(), 4);
      pin("add_states", {tr[0].st, tr[1].st, tr[2].st, tr[3].st}, 12'o0124);
      pin("add_retire", retires(), 1);
      pin("add_wb_rd", tr[3].rd, 1);
      play(99);

      // lw with 3 memory wait cycles: 8 cycles, MEM held 4.
      build(6'h23, 6'h00, 1'b0, 0, 3, 0);
      pin("lw_len", tr.size(), 8);
      pin("lw_wb_m2r", tr[7].m2r, 1);
      play(99);

      build(6'h04, 6'h00, 1'b1, 0, 0, 0);
      pin("beq_taken", {tr.size(), int'(tr[2].pcw)}, {3, 1});
      play(99);
      build(6'h04, 6'h00, 1'b0, 0, 0, 0);
      pin("beq_not_taken", tr[2].pcw, 0);
      play(99);

      build(6'h03, 6'h00, 1'b0, 0, 0, 0);
      pin("jal", {tr.size(), int'(tr[1].pcs), int'(tr[1].rd), int'(tr[1].m2r)}, {2, 2, 2, 2});
      play(99);

      build(6'h2B, 6'h00, 1'b0, 1, 2, 0);
      play(99);

      // Illegal opcode, 20 halt cycles, then reset back to FETCH.
      build(6'h3F, 6'h00, 1'b0, 0, 0, 20);
      pin("illegal", {tr.size(), int'(tr[21].flt)}, {22, 1});
      play(99);
      do_reset(2);

      // Fetch timeout.
      build(6'h00, 6'h20, 1'b0, TO, 0, 4);
      pin("timeout_len", tr.size(), TO + 4);
      play(99);
      do_reset(1);

      build(6'h00, 6'h0C, 1'b0, 0, 0, 3);
      play(99);
      do_reset(1);

      // Memory timeout during sw.
      build(6'h2B, 6'h00, 1'b0, 0, TO + 5, 3);
      play(99);
      do_reset(1);

      // Reset in the middle of an lw.
      build(6'h23, 6'h00, 1'b0, 0, 2, 0);
      play(4);
      do_reset(2);

      for (int n = 0; n < 200; n++) begin
         case ($urandom_range(0, 9))
            0:       op = 6'($urandom);
            1, 2:    op = 6'h00;
            default: op = pool[$urandom_range(0, 11)];
         endcase
         case ($urandom_range(0, 5))
            0:       func = 6'h08;
            1:       func = (n % 4 == 0) ? 6'h0C : 6'h20;
            default: func = 6'($urandom_range(16, 47));
         endcase
         fw = ($urandom_range(0, 29) == 0) ? TO + $urandom_range(0, 3) : $urandom_range(0, 3);
         mw = ($urandom_range(0, 19) == 0) ? TO + $urandom_range(0, 3) : $urandom_range(0, 4);
         build(op, func, 1'($urandom), fw, mw, $urandom_range(1, 5));
         if ($urandom_range(0, 9) == 0) begin
            cut = $urandom_range(1, tr.size());
            play(cut);
            do_reset($urandom_range(1, 2));
         end else begin
            play(99);
            if (tr[tr.size() - 1].st == 3'd7) do_reset(1);
         end
      end

      @(posedge clk);
      repeat (2) @(negedge clk);
      pin("queue_drained", q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/mc_ctrl.md
MC_CTRL -- requirements
Module: mc_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16: maximum mem_ready wait cycles before fault.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset; one clock, reset is asynchronous and active-low.
REQ-004 SHALL have port op_in  input  6  instruction opcode bits 31..26 from memory read data.
REQ-005 SHALL have port func_in  input  6  instruction bits 5..0 from memory read data.
REQ-006 SHALL have port alu_zero  input  1  ALU zero flag.
REQ-007 SHALL have port mem_ready  input  1  memory completes the current request this cycle.
REQ-008 SHALL have outputs mem_req (1), mem_sel (1: 0 instr, 1 data) and mem_we (1).
REQ-009 SHALL have outputs ir_we (1) and pc_we (1), plus pc_src (2: 0 PC+4, 1 branch target, 2 jump target, 3 rs).
REQ-010 SHALL have outputs reg_we (1), reg_dst (2: 0 rt, 1 rd, 2 r31) and mem_to_reg (2: 0 ALU, 1 mem, 2 PC+4).
REQ-011 SHALL have outputs alu_src (1: 1 imm), ext_mode (1: 1 sign) and alu_op (3: 0 add, 1 sub, 2 func, 3 and, 4 or, 5 slt, 6 lui).
REQ-012 SHALL have outputs state (3), retire (1), halted (1) and fault (2: 0 none, 1 illegal, 2 timeout).

Function
REQ-013 SHALL implement states FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=7.
REQ-014 SHALL latch op_in/func_in into internal op/func registers on the cycle ir_we=1; later decoding uses latched values only.
REQ-015 FETCH: mem_req=1, mem_sel=0; on mem_ready: ir_we=1, pc_we=1, pc_src=0, next DECODE; otherwise stay.
REQ-016 DECODE, j (0x02): pc_we=1, pc_src=2, retire=1 -> FETCH.
REQ-017 DECODE, jal (0x03): additionally reg_we=1, reg_dst=2, mem_to_reg=2, same cycle -> FETCH.
REQ-018 DECODE, R-type func 0x08 (jr): pc_we=1, pc_src=3, retire=1 -> FETCH; func 0x0C (syscall): retire=1 -> HALT, fault=0.
REQ-019 DECODE, supported opcodes 0x00, 0x04, 0x05, 0x08, 0x0A, 0x0C, 0x0D, 0x0F, 0x23, 0x2B -> EXEC; any other -> HALT, fault=1, no retire.
REQ-020 EXEC, beq (0x04)/bne (0x05): alu_op=1, alu_src=0; pc_we=alu_zero (beq) or !alu_zero (bne), pc_src=1, retire=1 -> FETCH.
REQ-021 EXEC, lw/sw: alu_op=0, alu_src=1, ext_mode=1 -> MEM.
REQ-022 EXEC, R-type/immediate ALU ops -> WB; alu_op/alu_src/ext_mode held through WB.
REQ-023 Mapping: R-type alu_op=2, alu_src=0; addi 0; slti 5; andi 3; ori 4; lui 6; addi/slti ext_mode=1; andi/ori/lui ext_mode=0.
REQ-024 MEM: mem_req=1, mem_sel=1, mem_we=1 for sw; on mem_ready: sw retire=1 -> FETCH; lw -> WB.
REQ-025 WB: reg_we=1 for exactly one cycle; reg_dst=1 for R-type, else 0; mem_to_reg=1 for lw, else 0; retire=1 -> FETCH.
REQ-026 A wait counter SHALL clear on entry to FETCH/MEM, increment each cycle mem_ready=0; reaching TIMEOUT -> HALT, fault=2, no strobes.
REQ-027 mem_ready outside FETCH/MEM SHALL be ignored.
REQ-028 HALT SHALL be absorbing until reset: halted=1, all write enables and mem_req 0.
REQ-029 All enables (pc_we, ir_we, reg_we, mem_we, retire) SHALL be combinational from state and latched op/func and never asserted in HALT or during reset.
REQ-030 Latencies: j/jal/jr 2 cycles, branch 3, R/imm 4, sw 4, lw 5, each plus memory wait cycles.

Reset
REQ-031 While rst_n=0: state=FETCH, op/func=0, wait counter=0, fault=0, halted=0.
REQ-032 Reset outputs: all enables 0, pc_src/reg_dst/mem_to_reg/alu_op=0; mem_req=0 until rst_n deasserts.
REQ-033 Reset asserted mid-instruction SHALL abort it with no further strobes; first cycle after release is FETCH.

Verification
REQ-034 add (op 0x00, func 0x20), mem_ready=1 always -> states 0,1,2,4,0; reg_we=1 and reg_dst=1 only in WB; retire pulses once.
REQ-035 lw (0x23) with mem_ready delayed 3 cycles in MEM -> MEM held 4 cycles, mem_we=0; WB has mem_to_reg=1; total 8 cycles.
REQ-036 beq with alu_zero=1, then alu_zero=0 -> pc_we=1 pc_src=1 in EXEC first time; pc_we=0 second; both return to FETCH.
REQ-037 jal (0x03) -> DECODE has pc_we=1, pc_src=2, reg_we=1, reg_dst=2, mem_to_reg=2; next state FETCH.
REQ-038 opcode 0x3F -> HALT, fault=1, halted=1; mem_req stays 0 for 20 cycles; rst_n pulse returns to FETCH, fault=0.
REQ-039 TIMEOUT=16, mem_ready held 0 in FETCH -> HALT after 16 cycles, fault=2, ir_we never asserted.
